// File: rtl/vpifo_task_dispatch.sv
// Task dispatcher for the virtualised SRAM PIFO ring: per-channel task FIFOs feeding root RPU
// slots (tree_id % LEVEL) with per-slot round-robin, per-tree issue gap and slot back-pressure.
module vpifo_task_dispatch #(
    parameter int unsigned PTW        = 16,
    parameter int unsigned MTW        = 0,
    parameter int unsigned LEVEL      = 4,
    parameter int unsigned TREE_NUM   = 4,
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned MIN_GAP    = 2,
    localparam int unsigned DW        = PTW + MTW,
    localparam int unsigned TB        = $clog2(TREE_NUM),
    localparam int unsigned FW        = $clog2(FIFO_DEPTH)
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [NUM_CH-1:0]        i_task_valid,
    input  logic [NUM_CH-1:0]        i_task_push,
    input  logic [NUM_CH-1:0]        i_task_pop,
    input  logic [NUM_CH*TB-1:0]     i_task_tree_id,
    input  logic [NUM_CH*DW-1:0]     i_task_data,
    output logic [NUM_CH-1:0]        o_task_ready,
    output logic [NUM_CH*(FW+1)-1:0] o_fifo_count,
    input  logic [LEVEL-1:0]         i_slot_busy,
    output logic [LEVEL-1:0]         o_rpu_push,
    output logic [LEVEL-1:0]         o_rpu_pop,
    output logic [LEVEL*TB-1:0]      o_rpu_tree_id,
    output logic [LEVEL*DW-1:0]      o_rpu_push_data,
    output logic [15:0]              o_drop_cnt
);
    localparam int unsigned CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned SW = $clog2(LEVEL);
    localparam int unsigned GW = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;

    typedef struct packed {
        logic          push;
        logic          pop;
        logic [TB-1:0] tree;
        logic [DW-1:0] data;
    } entry_t;

    entry_t              head    [NUM_CH];
    logic [SW-1:0]       slot_of [NUM_CH];
    logic [NUM_CH-1:0]   nonempty;
    logic [NUM_CH-1:0]   wr_en;
    logic [NUM_CH-1:0]   drop;
    logic [NUM_CH-1:0]   elig;
    logic [NUM_CH-1:0]   rd_en;
    logic [TREE_NUM-1:0] cool_zero;
    logic [TREE_NUM-1:0] cool_set;
    logic [CW-1:0]       rr_ptr  [LEVEL];
    logic [LEVEL-1:0]    gnt_vld;
    logic [CW-1:0]       gnt_ch  [LEVEL];
    logic [CW-1:0]       arb_idx;
    logic [15:0]         drop_q;
    logic [15:0]         drop_d;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        entry_t        mem_q [FIFO_DEPTH];
        logic [FW-1:0] wr_ptr_q;
        logic [FW-1:0] rd_ptr_q;
        logic [FW:0]   count_q;

        assign head[c]         = mem_q[rd_ptr_q];
        assign slot_of[c]      = SW'(32'(head[c].tree) % LEVEL);
        assign nonempty[c]     = (count_q != '0);
        assign o_task_ready[c] = (count_q != (FW+1)'(FIFO_DEPTH));
        assign wr_en[c]        = i_task_valid[c] & o_task_ready[c]
                               & (i_task_push[c] | i_task_pop[c]);
        assign drop[c]         = i_task_valid[c] & o_task_ready[c]
                               & ~(i_task_push[c] | i_task_pop[c]);
        assign elig[c]         = nonempty[c] & cool_zero[head[c].tree]
                               & ~i_slot_busy[slot_of[c]];
        assign o_fifo_count[c*(FW+1) +: FW+1] = count_q;

        // Storage is not reset; the pointers alone define which entries are live.
        always_ff @(posedge i_clk) begin
            if (wr_en[c]) begin
                mem_q[wr_ptr_q] <= '{push: i_task_push[c],
                                     pop:  i_task_pop[c],
                                     tree: i_task_tree_id[c*TB +: TB],
                                     data: i_task_data[c*DW +: DW]};
            end
        end

        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (wr_en[c]) wr_ptr_q <= wr_ptr_q + FW'(1);
                if (rd_en[c]) rd_ptr_q <= rd_ptr_q + FW'(1);
                count_q <= count_q + (FW+1)'(wr_en[c]) - (FW+1)'(rd_en[c]);
            end
        end
    end

    for (genvar t = 0; t < TREE_NUM; t++) begin : g_tree
        logic [GW-1:0] cool_q;

        assign cool_zero[t] = (cool_q == '0);

        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                cool_q <= '0;
            end else if (cool_set[t]) begin
                cool_q <= GW'(MIN_GAP - 1);
            end else if (!cool_zero[t]) begin
                cool_q <= cool_q - GW'(1);
            end
        end
    end

    // Each head maps to exactly one slot, so per-slot searches never grant a channel twice.
    always_comb begin
        gnt_vld  = '0;
        rd_en    = '0;
        cool_set = '0;
        arb_idx  = '0;
        for (int s = 0; s < LEVEL; s++) begin
            gnt_ch[s] = '0;
            for (int k = 0; k < NUM_CH; k++) begin
                arb_idx = CW'((32'(rr_ptr[s]) + 32'(k)) % NUM_CH);
                if (!gnt_vld[s] && elig[arb_idx] && (slot_of[arb_idx] == SW'(s))) begin
                    gnt_vld[s] = 1'b1;
                    gnt_ch[s]  = arb_idx;
                end
            end
            if (gnt_vld[s]) begin
                rd_en[gnt_ch[s]]               = 1'b1;
                cool_set[head[gnt_ch[s]].tree] = 1'b1;
            end
        end
    end

    for (genvar s = 0; s < LEVEL; s++) begin : g_slot
        entry_t        gnt_e;
        logic [CW-1:0] rr_q;
        logic          push_q;
        logic          pop_q;
        logic [TB-1:0] tree_q;
        logic [DW-1:0] data_q;

        assign gnt_e                       = head[gnt_ch[s]];
        assign rr_ptr[s]                   = rr_q;
        assign o_rpu_push[s]               = push_q;
        assign o_rpu_pop[s]                = pop_q;
        assign o_rpu_tree_id[s*TB +: TB]   = tree_q;
        assign o_rpu_push_data[s*DW +: DW] = data_q;

        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                rr_q   <= '0;
                push_q <= 1'b0;
                pop_q  <= 1'b0;
                tree_q <= '0;
                data_q <= '0;
            end else begin
                push_q <= gnt_vld[s] & gnt_e.push;
                pop_q  <= gnt_vld[s] & gnt_e.pop;
                tree_q <= gnt_vld[s] ? gnt_e.tree : '0;
                data_q <= (gnt_vld[s] && gnt_e.push) ? gnt_e.data : '1;
                if (gnt_vld[s]) rr_q <= CW'((32'(gnt_ch[s]) + 32'd1) % NUM_CH);
            end
        end
    end

    always_comb begin
        drop_d = drop_q;
        for (int c = 0; c < NUM_CH; c++) begin
            if (drop[c] && (drop_d != 16'hFFFF)) drop_d = drop_d + 16'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) drop_q <= '0;
        else       drop_q <= drop_d;
    end

    assign o_drop_cnt = drop_q;

endmodule

// File: doc/vpifo_task_dispatch.md
Name: vpifo_task_dispatch

Overview:
- Multi-channel task front-end for the virtualised SRAM PIFO ring; parametrised successor to the per-level task FIFO plus distributor pair.
- Buffers push/pop tasks from NUM_CH client channels in per-channel FIFOs.
- Dispatches each FIFO head to the root RPU slot owning its tree (tree_id % LEVEL), with per-slot round-robin fairness, per-tree minimum issue gap and slot-busy back-pressure.
- Outputs drive the RPU injection muxes (rpu_push/rpu_pop/rpu_treeId/rpu_push_data).

Parameters:
PTW, 16, payload width
MTW, 0, metadata width; DW = PTW+MTW
LEVEL, 4, number of RPU slots in the ring, >=2
TREE_NUM, 4, number of virtual trees, >=2; TB = $clog2(TREE_NUM)
NUM_CH, 4, number of client channels, >=1
FIFO_DEPTH, 8, entries per channel FIFO, power of 2; FW = $clog2(FIFO_DEPTH)
MIN_GAP, 2, minimum cycles between two dispatches to the same tree, >=1

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous reset, active-high
i_task_valid  in  NUM_CH  per-channel task strobe
i_task_push  in  NUM_CH  task contains a push
i_task_pop  in  NUM_CH  task contains a pop
i_task_tree_id  in  NUM_CH*TB  target tree per channel
i_task_data  in  NUM_CH*DW  push payload per channel
o_task_ready  out  NUM_CH  channel FIFO not full
o_fifo_count  out  NUM_CH*(FW+1)  occupancy per channel
i_slot_busy  in  LEVEL  RPU slot carries a pipelined op this cycle; no injection allowed
o_rpu_push  out  LEVEL  inject push at slot
o_rpu_pop  out  LEVEL  inject pop at slot
o_rpu_tree_id  out  LEVEL*TB  tree of injected op
o_rpu_push_data  out  LEVEL*DW  payload of injected push
o_drop_cnt  out  16  count of accepted strobes with neither push nor pop

Behaviour:
- Single clock domain; all state updates on posedge i_clk.
- Reset: synchronous, active-high. Clears all FIFO pointers/counts, tree cooldowns, RR pointers and o_drop_cnt. Next cycle: o_rpu_push = o_rpu_pop = 0, o_rpu_tree_id = 0, o_rpu_push_data = 0, o_task_ready = all 1. Reset mid-operation discards queued tasks and any decision being made in that cycle.
- Accept: o_task_ready[c] = (count[c] != FIFO_DEPTH), combinational from the registered count. Write when valid & ready. A write to a full FIFO is ignored even if a read occurs in the same cycle.
- Drop: valid & ready with push = pop = 0 is not stored; o_drop_cnt += 1, saturating at 0xFFFF.
- No bypass: an entry written in cycle N is first eligible as head in cycle N+1.
- Slot mapping: slot(c) = head_tree[c] % LEVEL.
- Eligibility of channel c in cycle N requires all of:
  - FIFO c non-empty;
  - cooldown[head_tree[c]] == 0;
  - i_slot_busy[slot(c)] == 0.
- Arbitration: per slot s, independently. Among eligible channels mapping to s, grant the first at or after rr_ptr[s], searching cyclically over 0..NUM_CH-1. Then rr_ptr[s] <= winner+1 mod NUM_CH; rr_ptr[s] is unchanged when there is no grant.
- At most one grant per slot and per channel per cycle (a head maps to exactly one slot). Granted heads pop in cycle N. Per-channel order is strict FIFO; head-of-line blocking is intended.
- Output register: grants in cycle N appear on o_rpu_* in cycle N+1 for exactly one cycle.
  - o_rpu_push[s] and o_rpu_pop[s] are copied from the entry's flags; both set means a combined push-pop in the same cycle.
  - o_rpu_push_data[s] is the stored payload when push = 1, otherwise all 1s.
  - o_rpu_tree_id[s] is the tree id of a granted slot, otherwise 0.
- Cooldown: on grant for tree t, cooldown[t] <= MIN_GAP-1. Each nonzero cooldown decrements by 1 per cycle. A tree granted in cycle N is next grantable in cycle N+MIN_GAP. MIN_GAP=1 allows back-to-back grants.
- Latency: minimum from accepted strobe to RPU output is 2 cycles (accept N, grant N+1, output N+2).
- Count update: count += write - read, evaluated in the same cycle. Pointers wrap modulo FIFO_DEPTH.

Test Plan:
- Reset: hold i_rst for 3 cycles with traffic applied -> o_rpu_* all 0, o_task_ready = 4'b1111, o_fifo_count all 0; after release, pre-reset tasks never appear.
- Latency: channel 0 push tree 2, data 0x00A5 at cycle 10 -> cycle 12: o_rpu_push = 4'b0100, o_rpu_tree_id[slot2] = 2, o_rpu_push_data[slot2] = 0x00A5.
- Round-robin: channels 0-3 each hold 2 pops to tree 1 (slot 1), MIN_GAP = 1 -> slot 1 grants in order ch0, ch1, ch2, ch3, ch0, ch1, ch2, ch3, one per cycle.
- Cooldown and busy: MIN_GAP = 3, two pushes to tree 0 on ch0; i_slot_busy[0] = 1 on the first eligible cycle -> first grant delayed 1 cycle; second grant exactly 3 cycles after the first.
- Full and drop: 9 writes to ch1 with no drain (slot busy) -> 8 accepted, ready = 0 on the 9th, count = 8. Then one strobe with push = pop = 0 on ch2 -> o_drop_cnt = 1, ch2 count stays 0.
- Combined op and parallelism: ch0 push+pop tree 3 while ch1 pushes tree 0, same cycle -> next-but-one cycle: slot 3 shows push = 1, pop = 1; slot 0 shows push = 1; both issued in the same cycle.
